simd_add_unpack: RTL

SIMD_ADD_UNPACK -- requirements
Module: simd_add_unpack

---
 rtl/simd_add_unpack.sv | 118 +++++++++++
 1 files changed

// File: rtl/simd_add_unpack.sv
// Unpacks a 48-bit SIMD result word (4x12 or 2x24 lanes) into a stream of
// individually handshaked lanes, skipping lanes disabled by the mask.
//
// state | meaning
// IDLE  | waiting for a packed word; in_ready high when enabled
// DRAIN | presenting enabled lanes of the held word, lowest index first
module simd_add_unpack #(
    parameter int PACK_W     = 48,
    parameter int LANE_MAX_W = 24
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ap_ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PACK_W-1:0]     in_data,
    input  logic                  in_mode,
    input  logic [3:0]            in_mask,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANE_MAX_W-1:0] out_data,
    output logic [1:0]            out_lane,
    output logic                  out_last
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    logic [0:0]            state;
    logic [PACK_W-1:0]     hold_data;
    logic                  hold_mode;
    logic [3:0]            hold_mask;

    logic [3:0]            eff_mask;
    logic                  accept;
    logic                  handshake;

    logic [3:0]            sel_mask;
    logic [PACK_W-1:0]     sel_data;
    logic                  sel_mode;
    logic [1:0]            sel_idx;
    logic [3:0]            sel_rest;
    logic [11:0]           sel_l12;
    logic [23:0]           sel_l24;
    logic [LANE_MAX_W-1:0] sel_lane;

    assign eff_mask  = in_mode ? {2'b00, in_mask[1:0]} : in_mask;
    assign in_ready  = (state == IDLE) & ap_ce & ap_rst_n;
    assign accept    = in_valid & in_ready;
    assign handshake = out_valid & out_ready & ap_ce;

    // In IDLE the lane picker looks at the incoming word so the first lane is
    // registered on the accept edge; in DRAIN it looks at the remaining lanes.
    always_comb begin
        sel_mask = (state == IDLE) ? eff_mask : hold_mask;
        sel_data = (state == IDLE) ? in_data  : hold_data;
        sel_mode = (state == IDLE) ? in_mode  : hold_mode;
        sel_idx  = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (sel_mask[i]) sel_idx = i[1:0];
        end
        sel_rest = sel_mask & ~(4'b0001 << sel_idx);
        case (sel_idx)
            2'd0:    sel_l12 = sel_data[11:0];
            2'd1:    sel_l12 = sel_data[23:12];
            2'd2:    sel_l12 = sel_data[35:24];
            default: sel_l12 = sel_data[47:36];
        endcase
        sel_l24  = sel_idx[0] ? sel_data[47:24] : sel_data[23:0];
        sel_lane = sel_mode ? sel_l24 : {{(LANE_MAX_W-12){1'b0}}, sel_l12};
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state     <= IDLE;
            hold_data <= '0;
            hold_mode <= 1'b0;
            hold_mask <= 4'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_lane  <= 2'd0;
            out_last  <= 1'b0;
        end else if (ap_ce) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        hold_data <= in_data;
                        hold_mode <= in_mode;
                        if (eff_mask != 4'b0) begin
                            state     <= DRAIN;
                            out_valid <= 1'b1;
                            out_data  <= sel_lane;
                            out_lane  <= sel_idx;
                            out_last  <= (sel_rest == 4'b0);
                            hold_mask <= sel_rest;
                        end else begin
                            hold_mask <= 4'b0;
                        end
                    end
                end
                default: begin
                    if (handshake) begin
                        if (out_last) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                        end else begin
                            out_data  <= sel_lane;
                            out_lane  <= sel_idx;
                            out_last  <= (sel_rest == 4'b0);
                            hold_mask <= sel_rest;
                        end
                    end
                end
            endcase
        end
    end

endmodule
